imem_arbiter: RTL and testbench

- Shares one `imem` instance between two requesters: instruction fetch (read-only) and program loader/debug (read/write).
- Translates a linear word address into the memory's X/Y row/column addresses.
- Sequences the memory's one-cycle registered read and returns data over valid/ready response channels.
- Sits between the fetch stage/loader and `imem`; it is the only driver of the memory's inputs.

---
 rtl/imem_pkg.sv | 18 +
 rtl/rr_arb2.sv | 36 +++
 rtl/imem_arbiter.sv | 127 ++++++++++++
 tb/tb_imem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and default sizes for the imem arbiter and its round-robin helper.
package imem_pkg;

  localparam int ADDR_BITS  = 4;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_LOAD  = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a single requester always wins, a tie goes to
// whichever port was not granted last. last_q only moves when update_i is set.
module rr_arb2
  import imem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,        // [0] fetch, [1] loader
  input  logic       update_i,
  output req_id_e    gnt_o,
  output logic       gnt_valid_o
);

  req_id_e last_q;

  always_comb begin
    gnt_valid_o = |req_i;
    case (req_i)
      2'b10:   gnt_o = REQ_LOAD;
      2'b11:   gnt_o = (last_q == REQ_FETCH) ? REQ_LOAD : REQ_FETCH;
      default: gnt_o = REQ_FETCH;
    endcase
  end

  // Reset to "loader went last" so the first tie after reset goes to fetch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= REQ_LOAD;
    end else if (update_i && gnt_valid_o) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      last_q <= gnt_o;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one imem between instruction fetch and the loader: arbitrates, splits the
// linear address into X/Y, sequences the registered read and returns valid/ready data.
module imem_arbiter #(
  parameter int ADDR_BITS  = imem_pkg::ADDR_BITS,
  parameter int DATA_WIDTH = imem_pkg::DATA_WIDTH
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   f_req_valid,
  output logic                   f_req_ready,
  input  logic [2*ADDR_BITS-1:0] f_req_addr,
  output logic                   f_rsp_valid,
  input  logic                   f_rsp_ready,
  output logic [DATA_WIDTH-1:0]  f_rsp_data,
  input  logic                   l_req_valid,
  output logic                   l_req_ready,
  input  logic                   l_req_we,
  input  logic [2*ADDR_BITS-1:0] l_req_addr,
  input  logic [DATA_WIDTH-1:0]  l_req_wdata,
  output logic                   l_rsp_valid,
  input  logic                   l_rsp_ready,
  output logic [DATA_WIDTH-1:0]  l_rsp_data,
  output logic                   mem_we,
  output logic [ADDR_BITS-1:0]   mem_x_addr,
  output logic [ADDR_BITS-1:0]   mem_y_addr,
  output logic [DATA_WIDTH-1:0]  mem_data_in,
  input  logic [DATA_WIDTH-1:0]  mem_data_out
);

  import imem_pkg::*;

  localparam int AW = 2 * ADDR_BITS;

  state_e                state_q,  state_d;
  req_id_e               owner_q,  owner_d;
  logic [DATA_WIDTH-1:0] f_data_q, f_data_d;
  logic [DATA_WIDTH-1:0] l_data_q, l_data_d;

  req_id_e arb_gnt;
  logic    arb_gnt_valid;
  logic    grant;

  rr_arb2 u_arb (
    .clk_i       (Clock),
    .rst_i       (Reset),
    .req_i       ({l_req_valid, f_req_valid}),
    .update_i    (grant),
    .gnt_o       (arb_gnt),
    .gnt_valid_o (arb_gnt_valid)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    f_data_d    = f_data_q;
    l_data_d    = l_data_q;
    grant       = 1'b0;
    f_req_ready = 1'b0;
    l_req_ready = 1'b0;
    f_rsp_valid = 1'b0;
    l_rsp_valid = 1'b0;
    mem_we      = 1'b0;
    mem_x_addr  = '0;
    mem_y_addr  = '0;
    mem_data_in = '0;

    case (state_q)
      IDLE: begin
        // Gating on Reset keeps mem_we and the readies low while Reset is held.
        if (arb_gnt_valid && !Reset) begin
          grant   = 1'b1;
          owner_d = arb_gnt;
          state_d = WAIT;
          if (arb_gnt == REQ_FETCH) begin
            f_req_ready = 1'b1;
            mem_x_addr  = f_req_addr[AW-1:ADDR_BITS];
            mem_y_addr  = f_req_addr[ADDR_BITS-1:0];
          end else begin
            l_req_ready = 1'b1;
            mem_x_addr  = l_req_addr[AW-1:ADDR_BITS];
            mem_y_addr  = l_req_addr[ADDR_BITS-1:0];
            mem_data_in = l_req_wdata;
            mem_we      = l_req_we;
          end
        end
      end

      WAIT: begin
        if (owner_q == REQ_FETCH) f_data_d = mem_data_out;
        else                      l_data_d = mem_data_out;
        state_d = RESP;
      end

      RESP: begin
        if (owner_q == REQ_FETCH) begin
          f_rsp_valid = 1'b1;
          if (f_rsp_ready) state_d = IDLE;
        end else begin
          l_rsp_valid = 1'b1;
          if (l_rsp_ready) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      owner_q  <= REQ_FETCH;
      f_data_q <= '0;
      l_data_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      f_data_q <= f_data_d;
      l_data_q <= l_data_d;
    end
  end

  assign f_rsp_data = f_data_q;
  assign l_rsp_data = l_data_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural read-before-write imem and a
// scoreboard monitor checking grant order and response data.
module tb_imem_arbiter;

  localparam int AB = 4;
  localparam int DW = 32;

  logic          Clock, Reset;
  logic          f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready;
  logic [2*AB-1:0] f_req_addr;
  logic [DW-1:0] f_rsp_data;
  logic          l_req_valid, l_req_ready, l_req_we, l_rsp_valid, l_rsp_ready;
  logic [2*AB-1:0] l_req_addr;
  logic [DW-1:0] l_req_wdata, l_rsp_data;
  logic          mem_we;
  logic [AB-1:0] mem_x_addr, mem_y_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  bit          gnt_exp_q[$];   // 0 = fetch, 1 = loader
  logic [DW-1:0] f_exp_q[$];
  logic [DW-1:0] l_exp_q[$];

  imem_arbiter #(.ADDR_BITS(AB), .DATA_WIDTH(DW)) dut (
    .Clock(Clock), .Reset(Reset),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_we(l_req_we),
    .l_req_addr(l_req_addr), .l_req_wdata(l_req_wdata),
    .l_rsp_valid(l_rsp_valid), .l_rsp_ready(l_rsp_ready), .l_rsp_data(l_rsp_data),
    .mem_we(mem_we), .mem_x_addr(mem_x_addr), .mem_y_addr(mem_y_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cycle <= cycle + 1;

  // imem model: unwritten words read as 0xA500_00<addr>; reads the old word
  // on the same edge that a write lands.
  logic [DW-1:0] mem [256];
  bit            wr  [256];
  always @(posedge Clock) begin
    mem_data_out <= wr[{mem_x_addr, mem_y_addr}] ? mem[{mem_x_addr, mem_y_addr}]
                                                 : (32'hA500_0000 | DW'({mem_x_addr, mem_y_addr}));
    if (mem_we) begin
      mem[{mem_x_addr, mem_y_addr}] <= mem_data_in;
      wr[{mem_x_addr, mem_y_addr}]  <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge Clock) begin
    if (f_req_valid && f_req_ready) begin
      if (gnt_exp_q.size() == 0) check("grant_unexpected_f", 1, 0);
      else                       check("grant_order", 0, 32'(gnt_exp_q.pop_front()));
      check("grant_exclusive", 32'(l_req_ready), 0);
    end
    if (l_req_valid && l_req_ready) begin
      if (gnt_exp_q.size() == 0) check("grant_unexpected_l", 1, 0);
      else                       check("grant_order", 1, 32'(gnt_exp_q.pop_front()));
    end
    if (f_rsp_valid && f_rsp_ready) begin
      check("f_rsp_exclusive", 32'(l_rsp_valid), 0);
      if (f_exp_q.size() == 0) check("f_rsp_unexpected", 1, 0);
      else                     check("f_rsp_data", f_rsp_data, f_exp_q.pop_front());
    end
    if (l_rsp_valid && l_rsp_ready) begin
      if (l_exp_q.size() == 0) check("l_rsp_unexpected", 1, 0);
      else                     check("l_rsp_data", l_rsp_data, l_exp_q.pop_front());
    end
  end

  task automatic wait_accept(input bit ld, output int cyc);
    int n = 0;
    bit ok = 0;
    while (!ok && n < 50) begin
      @(negedge Clock);
      if (ld ? (l_req_valid && l_req_ready) : (f_req_valid && f_req_ready)) ok = 1;
      n++;
    end
    cyc = cycle;
    if (!ok) check(ld ? "l_accept_timeout" : "f_accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input bit ld, output int cyc);
    int n = 0;
    bit ok = 0;
    while (!ok && n < 50) begin
      @(negedge Clock);
      if (ld ? l_rsp_valid : f_rsp_valid) ok = 1;
      n++;
    end
    cyc = cycle;
    if (!ok) check(ld ? "l_rsp_timeout" : "f_rsp_timeout", 0, 1);
  endtask

  task automatic do_fetch(input logic [7:0] addr, input logic [31:0] exp);
    int t0, t1;
    gnt_exp_q.push_back(1'b0);
    f_exp_q.push_back(exp);
    f_req_addr  = addr;
    f_req_valid = 1'b1;
    wait_accept(0, t0);
    @(posedge Clock) #1 f_req_valid = 1'b0;
    wait_rsp(0, t1);
    check("f_latency", 32'(t1 - t0), 2);
    @(posedge Clock) #1;
  endtask

  task automatic do_load(input bit we, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp);
    int t0, t1;
    gnt_exp_q.push_back(1'b1);
    l_exp_q.push_back(exp);
    l_req_we    = we;
    l_req_addr  = addr;
    l_req_wdata = wdata;
    l_req_valid = 1'b1;
    wait_accept(1, t0);
    check("issue_mem_we", 32'(mem_we), 32'(we));
    check("issue_x_addr", 32'(mem_x_addr), 32'(addr[7:4]));
    check("issue_y_addr", 32'(mem_y_addr), 32'(addr[3:0]));
    if (we) check("issue_data_in", mem_data_in, wdata);
    @(posedge Clock) #1 l_req_valid = 1'b0;
    wait_rsp(1, t1);
    check("l_latency", 32'(t1 - t0), 2);
    @(posedge Clock) #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, n, n_acc, last_t;

    // Reset held with both requesters valid
    Reset = 1'b1;
    f_rsp_ready = 1'b1; l_rsp_ready = 1'b1;
    f_req_valid = 1'b1; f_req_addr = 8'h23;
    l_req_valid = 1'b1; l_req_we = 1'b0; l_req_addr = 8'h05; l_req_wdata = '0;
    gnt_exp_q.push_back(1'b0); gnt_exp_q.push_back(1'b1);
    f_exp_q.push_back(32'hA500_0023);
    l_exp_q.push_back(32'hA500_0005);
    repeat (2) begin
      @(negedge Clock);
      check("rst_f_req_ready", 32'(f_req_ready), 0);
      check("rst_l_req_ready", 32'(l_req_ready), 0);
      check("rst_f_rsp_valid", 32'(f_rsp_valid), 0);
      check("rst_l_rsp_valid", 32'(l_rsp_valid), 0);
      check("rst_mem_we",      32'(mem_we), 0);
    end
    @(posedge Clock) #1 Reset = 1'b0;
    wait_accept(0, t0);
    @(posedge Clock) #1 f_req_valid = 1'b0;
    wait_accept(1, t0);
    @(posedge Clock) #1 l_req_valid = 1'b0;
    wait_rsp(1, t1);
    @(posedge Clock) #1;

    // Fairness: both held valid for six transactions
    f_req_addr = 8'h30; l_req_addr = 8'h31; l_req_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      gnt_exp_q.push_back(1'b0); gnt_exp_q.push_back(1'b1);
      f_exp_q.push_back(32'hA500_0030);
      l_exp_q.push_back(32'hA500_0031);
    end
    f_req_valid = 1'b1; l_req_valid = 1'b1;
    n = 0; n_acc = 0; last_t = 0;
    while (n_acc < 6 && n < 100) begin
      @(negedge Clock);
      n++;
      if ((f_req_valid && f_req_ready) || (l_req_valid && l_req_ready)) begin
        if (n_acc > 0) check("fair_gap", 32'(cycle - last_t), 3);
        last_t = cycle;
        n_acc++;
      end
    end
    check("fair_count", 32'(n_acc), 6);
    @(posedge Clock) #1 begin f_req_valid = 1'b0; l_req_valid = 1'b0; end
    wait_rsp(1, t1);
    @(posedge Clock) #1;

    // Loader write then fetch read
    do_load(1'b1, 8'h23, 32'hDEAD_BEEF, 32'hA500_0023);
    do_fetch(8'h23, 32'hDEAD_BEEF);

    // Write returns previous contents
    do_load(1'b1, 8'h05, 32'h1111_1111, 32'hA500_0005);
    do_load(1'b1, 8'h05, 32'h2222_2222, 32'h1111_1111);
    do_load(1'b0, 8'h05, 32'h0, 32'h2222_2222);

    // Backpressure on the fetch response while the loader waits
    do_load(1'b1, 8'h40, 32'h1234_5678, 32'hA500_0040);
    f_rsp_ready = 1'b0;
    gnt_exp_q.push_back(1'b0);
    f_exp_q.push_back(32'h1234_5678);
    f_req_addr = 8'h40; f_req_valid = 1'b1;
    wait_accept(0, t0);
    @(posedge Clock) #1 begin
      f_req_valid = 1'b0;
      l_req_we = 1'b0; l_req_addr = 8'h41; l_req_valid = 1'b1;
      gnt_exp_q.push_back(1'b1);
      l_exp_q.push_back(32'hA500_0041);
    end
    wait_rsp(0, t1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge Clock);
      check("bp_f_rsp_valid", 32'(f_rsp_valid), 1);
      check("bp_f_rsp_data",  f_rsp_data, 32'h1234_5678);
      check("bp_l_req_ready", 32'(l_req_ready), 0);
    end
    @(posedge Clock) #1 f_rsp_ready = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    check("bp_release_f_rsp_valid", 32'(f_rsp_valid), 0);
    check("bp_release_l_grant",     32'(l_req_ready), 1);
    @(posedge Clock) #1 l_req_valid = 1'b0;
    wait_rsp(1, t1);
    @(posedge Clock) #1;

    // Reset while a loader write sits in WAIT
    gnt_exp_q.push_back(1'b1);
    l_req_we = 1'b1; l_req_addr = 8'h0F; l_req_wdata = 32'hCAFE_F00D; l_req_valid = 1'b1;
    wait_accept(1, t0);
    check("rstw_issue_we", 32'(mem_we), 1);
    @(posedge Clock) #1 begin
      Reset = 1'b1; l_req_valid = 1'b0;
      f_req_addr = 8'h0F; f_req_valid = 1'b1;
    end
    repeat (2) begin
      @(negedge Clock);
      check("rstw_mem_we",      32'(mem_we), 0);
      check("rstw_f_req_ready", 32'(f_req_ready), 0);
      check("rstw_l_rsp_valid", 32'(l_rsp_valid), 0);
    end
    @(posedge Clock) #1 begin Reset = 1'b0; f_req_valid = 1'b0; end
    repeat (4) begin
      @(negedge Clock);
      check("rstw_no_l_rsp", 32'(l_rsp_valid), 0);
    end
    @(posedge Clock) #1;
    do_load(1'b0, 8'h0F, 32'h0, 32'hCAFE_F00D);
    do_fetch(8'h0F, 32'hCAFE_F00D);

    repeat (3) @(negedge Clock);
    check("grant_q_drained", 32'(gnt_exp_q.size()), 0);
    check("f_exp_q_drained", 32'(f_exp_q.size()), 0);
    check("l_exp_q_drained", 32'(l_exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
